// File: rtl/spi_pkg.sv
// Shared types and defaults for the SPI slave receiver.
package spi_pkg;

  localparam int unsigned DATA_W_DEF     = 12;
  localparam int unsigned FIFO_DEPTH_DEF = 4;

  typedef enum logic [1:0] {
    StArmed  = 2'd0,
    StIdle   = 2'd1,
    StShift  = 2'd2,
    StWaitCs = 2'd3
  } rx_state_t;

endpackage

// File: rtl/spi_rx_fifo.sv
// Circular output buffer for received words; DEPTH = 1 degenerates to a holding register.
module spi_rx_fifo #(
  parameter int unsigned WIDTH = 12,
  parameter int unsigned DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(DEPTH - 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  cnt_q;
  logic             do_push, do_pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == LastPtr) ? '0 : p + 1'b1;
  endfunction

  assign full    = (cnt_q == CntW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot, so a push into a full buffer still lands.
  assign do_push = push & (~full | do_pop);
  assign data    = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (do_pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/spi_slave_rx.sv
// LSB-first SPI slave receiver with buffered word output.
// Define SPI_RX_FIFO_EN for a FIFO_DEPTH-entry buffer; otherwise a single holding register.
module spi_slave_rx
  import spi_pkg::*;
#(
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              cs,
  input  logic              mosi,
  output logic [DATA_W-1:0] dout,
  output logic              dvalid,
  input  logic              dready,
  output logic              busy,
  output logic              frame_err,
  output logic              overrun
);

  localparam int unsigned CntW = $clog2(DATA_W + 1);
`ifdef SPI_RX_FIFO_EN
  localparam int unsigned BufDepth = FIFO_DEPTH;
`else
  // Single holding register; FIFO_DEPTH only matters for the FIFO build.
  localparam int unsigned BufDepth = (FIFO_DEPTH > 0) ? 1 : 1;
`endif

  logic [1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
  logic       sclk_prev_q, cs_prev_q;
  logic       sclk_s, cs_s, mosi_s;
  logic       sclk_fall, cs_fall, cs_rise;
  logic [1:0] arm_cnt_q;

  rx_state_t         state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              push, pop, full, empty;
  logic              frame_err_q, frame_err_d;
  logic              overrun_q;

  assign sclk_s    = sclk_sync_q[1];
  assign cs_s      = cs_sync_q[1];
  assign mosi_s    = mosi_sync_q[1];
  assign sclk_fall = sclk_prev_q & ~sclk_s;
  assign cs_fall   = cs_prev_q & ~cs_s;
  assign cs_rise   = ~cs_prev_q & cs_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_sync_q <= 2'b00;
      cs_sync_q   <= 2'b11;
      mosi_sync_q <= 2'b00;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b1;
      arm_cnt_q   <= 2'd0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[0], sclk};
      cs_sync_q   <= {cs_sync_q[0], cs};
      mosi_sync_q <= {mosi_sync_q[0], mosi};
      sclk_prev_q <= sclk_s;
      cs_prev_q   <= cs_s;
      if (arm_cnt_q != 2'd3) begin
        arm_cnt_q <= arm_cnt_q + 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StArmed;
      cnt_q       <= '0;
      shreg_q     <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shreg_q     <= shreg_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= push & full & ~pop;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shreg_d     = shreg_q;
    push        = 1'b0;
    frame_err_d = 1'b0;
    unique case (state_q)
      // Hold off until the synchronizers carry real pin values, so a frame already
      // running across reset is never picked up halfway.
      StArmed: begin
        if ((arm_cnt_q == 2'd3) && cs_s) begin
          state_d = StIdle;
        end
      end
      StIdle: begin
        if (cs_fall) begin
          state_d = StShift;
          cnt_d   = '0;
          shreg_d = '0;
        end
      end
      StShift: begin
        if (cs_rise) begin
          frame_err_d = 1'b1;
          state_d     = StIdle;
          cnt_d       = '0;
          shreg_d     = '0;
        end else if (sclk_fall) begin
          shreg_d = shreg_q | (DATA_W'(mosi_s) << cnt_q);
          cnt_d   = cnt_q + 1'b1;
          if (cnt_d == CntW'(DATA_W)) begin
            state_d = StWaitCs;
          end
        end
      end
      StWaitCs: begin
        if (cs_rise) begin
          push    = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StArmed;
    endcase
  end

  assign pop = dvalid & dready;

  spi_rx_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (BufDepth)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (shreg_q),
    .pop   (pop),
    .data  (dout),
    .full  (full),
    .empty (empty)
  );

  assign dvalid    = ~empty;
  assign busy      = (state_q == StShift) || (state_q == StWaitCs);
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_spi_slave_rx.sv
// Randomized self-checking bench for spi_slave_rx against a queue-based frame model.
module tb_spi_slave_rx;

  localparam int DW = 12;
`ifdef SPI_RX_FIFO_EN
  localparam int DEPTH = 4;
`else
  localparam int DEPTH = 1;
`endif

  logic          clk, rst, sclk, cs, mosi, dready;
  logic [DW-1:0] dout;
  logic          dvalid, busy, frame_err, overrun;

  int tests  = 0;
  int failed = 0;
  int ferr_cnt = 0;
  int ovr_cnt  = 0;
  int exp_ferr = 0;
  int exp_ovr  = 0;
  logic [DW-1:0] model_q[$];

  spi_slave_rx #(
    .DATA_W     (DW),
    .FIFO_DEPTH (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .sclk      (sclk),
    .cs        (cs),
    .mosi      (mosi),
    .dout      (dout),
    .dvalid    (dvalid),
    .dready    (dready),
    .busy      (busy),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse widths are counted in cycles, so a stretched pulse shows up as a count error.
  always @(posedge clk) begin
    if (frame_err === 1'b1) ferr_cnt <= ferr_cnt + 1;
    if (overrun === 1'b1)   ovr_cnt  <= ovr_cnt + 1;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drives one frame: cs low, nbits sclk pulses (data changes while sclk high), cs high.
  task automatic send_frame(input logic [31:0] bits, input int nbits, input bit pop_at_end,
                            input int rst_at);
    @(negedge clk);
    cs = 1'b0;
    repeat (8) @(negedge clk);
    check("busy_in_frame", busy, 1);
    for (int i = 0; i < nbits; i++) begin
      if (i == rst_at) begin
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
      end
      mosi = bits[i];
      sclk = 1'b1;
      repeat (4) @(negedge clk);
      sclk = 1'b0;
      repeat (4) @(negedge clk);
    end
    cs = 1'b1;
    if (pop_at_end) begin
      // The cs rise is seen two clocks later; pop on exactly that clock.
      repeat (2) @(negedge clk);
      dready = 1'b1;
      @(negedge clk);
      dready = 1'b0;
      repeat (5) @(negedge clk);
    end else begin
      repeat (8) @(negedge clk);
    end
    check("busy_after_frame", busy, 0);
  endtask

  // Frame plus its effect on the reference model.
  task automatic frame(input logic [31:0] bits, input int nbits, input bit pop_at_end);
    send_frame(bits, nbits, pop_at_end, -1);
    if (nbits < DW) begin
      exp_ferr++;
    end else begin
      if (pop_at_end && model_q.size() > 0) void'(model_q.pop_front());
      if (model_q.size() < DEPTH) model_q.push_back(bits[DW-1:0]);
      else exp_ovr++;
    end
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_frame_err"}, ferr_cnt, exp_ferr);
    check({tag, "_overrun"}, ovr_cnt, exp_ovr);
  endtask

  task automatic drain(input string tag);
    while (model_q.size() > 0) begin
      @(negedge clk);
      check({tag, "_dvalid"}, dvalid, 1);
      check({tag, "_dout"}, dout, model_q.pop_front());
      dready = 1'b1;
      @(negedge clk);
      dready = 1'b0;
    end
    @(negedge clk);
    check({tag, "_empty"}, dvalid, 0);
  endtask

  initial begin
    logic [31:0] w;
    int n;
    rst = 1'b1; cs = 1'b1; sclk = 1'b0; mosi = 1'b0; dready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_dout", dout, 0);
    check("rst_dvalid", dvalid, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_overrun", overrun, 0);
    rst = 1'b0;
    repeat (10) @(negedge clk);

    // Basic 12-bit frame.
    frame(32'hA5C, DW, 1'b0);
    check("basic_dout", dout, 32'hA5C);
    check("basic_dvalid", dvalid, 1);
    check_counts("basic");
    drain("basic");

    // Short frame.
    frame($urandom, 7, 1'b0);
    check_counts("short");
    check("short_dvalid", dvalid, 0);

    // Overflow with consumer stalled.
    frame(32'h111, DW, 1'b0);
    frame(32'h222, DW, 1'b0);
    for (int i = 2; i < DEPTH + 1; i++) frame($urandom, DW, 1'b0);
    check("ovf_head", dout, 32'h111);
    check_counts("ovf");
    drain("ovf");

    // Reset in the middle of a frame; the remainder of that frame must be ignored.
    send_frame($urandom, DW, 1'b0, 5);
    check("rstmid_dvalid", dvalid, 0);
    check_counts("rstmid");
    frame(32'h3C3, DW, 1'b0);
    check("rstmid_next", dout, 32'h3C3);
    drain("rstmid");

    // Extra sclk edges past the word are ignored.
    frame(32'h0FFF, DW + 2, 1'b0);
    check("long_dout", dout, 32'hFFF);
    check_counts("long");
    drain("long");

    // Push and pop on the same clock while full.
    for (int i = 0; i < DEPTH; i++) frame($urandom, DW, 1'b0);
    frame($urandom, DW, 1'b1);
    check_counts("pushpop");
    drain("pushpop");

    // Random frame lengths and contents.
    for (int k = 0; k < 10; k++) begin
      w = $urandom;
      n = $urandom_range(4, DW + 3);
      frame(w, n, 1'b0);
      check_counts("rand");
      drain("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/spi_slave_rx.md
SPI_SLAVE_RX -- requirements
Module: spi_slave_rx

Interface
REQ-001 The block SHALL have parameter DATA_W, default 12, meaning the frame word width in bits.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 4, meaning the number of output buffer entries (used only when SPI_RX_FIFO_EN is defined).
REQ-003 The block SHALL have port clk, input, 1 bit: system clock. All logic is on the rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-005 The block SHALL have port sclk, input, 1 bit: serial clock, asynchronous to clk.
REQ-006 The block SHALL have port cs, input, 1 bit: chip select, active-low, asynchronous.
REQ-007 The block SHALL have port mosi, input, 1 bit: serial data, LSB first.
REQ-008 The block SHALL have port dout, output, DATA_W bits: received word at the head of the buffer.
REQ-009 The block SHALL have port dvalid, output, 1 bit: dout holds a valid word.
REQ-010 The block SHALL have port dready, input, 1 bit: the consumer accepts dout when dvalid and dready are both high.
REQ-011 The block SHALL have port busy, output, 1 bit: a frame is in progress.
REQ-012 The block SHALL have port frame_err, output, 1 bit: one-clk pulse on a short frame.
REQ-013 The block SHALL have port overrun, output, 1 bit: one-clk pulse when a completed word is dropped.

Function
REQ-014 sclk, cs and mosi SHALL each pass through a 2-flop synchronizer, followed by one edge-detect register for sclk and cs.
REQ-015 The FSM SHALL have states IDLE, SHIFT, WAIT_CS and ARMED.
- ARMED: entered after reset.
- ARMED -> IDLE when synchronized cs is high.
REQ-016 IDLE -> SHIFT on a detected cs falling edge; the bit counter and shift register SHALL clear.
REQ-017 In SHIFT, each detected sclk falling edge SHALL sample synchronized mosi into bit position count (LSB first) and increment count.
REQ-018 SHIFT -> WAIT_CS when count reaches DATA_W; further sclk edges SHALL be ignored.
REQ-019 A detected cs rising edge in WAIT_CS SHALL push the word and return to IDLE; dvalid SHALL rise on the next clk.
REQ-020 A detected cs rising edge in SHIFT (count < DATA_W) SHALL pulse frame_err for 1 clk, discard the partial word and return to IDLE.
REQ-021 A pop occurs when dvalid and dready are both high; dout SHALL advance to the next entry on the following clk, or dvalid SHALL drop if the buffer is empty.
REQ-022 A push while the buffer is full SHALL pulse overrun, drop the new word and keep stored data intact.
REQ-023 A simultaneous push and pop while full SHALL succeed with no overrun.
REQ-024 busy SHALL be high in SHIFT and WAIT_CS.

Reset
REQ-025 On rst the following SHALL apply:
- state = ARMED;
- count and shift register = 0;
- buffer emptied;
- dout = 0, dvalid = 0, busy = 0, frame_err = 0, overrun = 0;
- synchronizers load cs = 1, sclk = 0, mosi = 0.
REQ-026 Reset mid-frame SHALL discard the partial word; the ARMED state prevents capture of a frame already in progress after reset.

Configuration
REQ-027 With macro SPI_RX_FIFO_EN defined, the buffer SHALL be a FIFO_DEPTH-entry circular FIFO with wrap-around read/write pointers.
REQ-028 Without SPI_RX_FIFO_EN, the buffer SHALL be a single holding register (depth 1) with identical handshake, overrun and reset behaviour.

Structure
REQ-029 Package spi_pkg SHALL hold the FSM state typedef (rx_state_t), DATA_W_DEF = 12 and FIFO_DEPTH_DEF = 4.
REQ-030 The buffer SHALL be sub-module spi_rx_fifo (push, pop, full, empty, data), instantiated for both configurations with depth 1 when the macro is absent.

Verification
REQ-031 cs low; 12 LSB-first bits of 0xA5C; cs high -> dout = 0xA5C, dvalid = 1, frame_err = 0.
REQ-032 cs low, 7 bits, cs high -> frame_err pulse for 1 clk, dvalid remains 0.
REQ-033 dready = 0; frames 0x111 then 0x222:
- without the macro -> dout = 0x111 and one overrun pulse;
- with the macro and 5 frames -> 4 stored, overrun on the 5th, pops yield the first four in order.
REQ-034 rst asserted after 5 bits of a frame -> no dvalid and no frame_err; the next full frame 0x3C3 is received correctly.
REQ-035 Frame of 14 sclk edges carrying 0xFFF followed by 2 zeros -> dout = 0xFFF.
REQ-036 With the FIFO full and dready = 1, a frame completes in the same clk as a pop -> no overrun, and the FIFO count is unchanged.
